// File: rtl/sysmon_pkg.sv
// Shared definitions for the system monitor serial link.
// Contents:
//   SOF_BYTE        start-of-frame marker that opens every frame
//   MAX_LEN_DEFAULT default maximum payload length in bytes
//   ADDR_W          register address width carried in the ADDR byte
//   rx_state_t      deframer FSM states
package sysmon_pkg;

  localparam logic [7:0] SOF_BYTE        = 8'hA5;
  localparam int         MAX_LEN_DEFAULT = 10;
  localparam int         ADDR_W          = 7;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    LEN  = 3'd2,
    DATA = 3'd3,
    CHK  = 3'd4
  } rx_state_t;

endpackage

// File: rtl/sysmon_frame_rx.sv
// Byte-stream deframer between the UART receiver and the system monitor
// register decode. Assembles SOF/ADDR/LEN/PAYLOAD/CHK frames, publishes the
// address and right-aligned payload of every good frame, and flags frames
// that are malformed, corrupted or stalled.
//
// Ports:
//   clk           system clock
//   reset         asynchronous reset, active-high
//   uart_rx_data  received byte, qualified by uart_rx_val
//   uart_rx_val   one-cycle strobe: uart_rx_data is valid
//   uartDisabled  1 = ignore all bytes and abort any frame in progress
//   rx_address    address of the last good frame
//   rx_data       payload of the last good frame, zero-extended,
//                 first payload byte most significant
//   rx_data_val   one-cycle pulse: rx_address/rx_data were just updated
//   rx_error      one-cycle pulse: a frame was discarded (LEN, CHK, timeout)
module sysmon_frame_rx
  import sysmon_pkg::*;
#(
  parameter int MAX_LEN        = MAX_LEN_DEFAULT,
  parameter int TIMEOUT_CYCLES = 8389
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             uart_rx_data,
  input  logic                   uart_rx_val,
  input  logic                   uartDisabled,
  output logic [ADDR_W-1:0]      rx_address,
  output logic [8*MAX_LEN-1:0]   rx_data,
  output logic                   rx_data_val,
  output logic                   rx_error
);

  localparam int DATA_W  = 8 * MAX_LEN;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [TIMER_W-1:0] TIMER_LIMIT = TIMER_W'(TIMEOUT_CYCLES);
  localparam logic [7:0]         LEN_LIMIT   = 8'(MAX_LEN);

  rx_state_t state_reg, state_next;

  logic [ADDR_W-1:0]  addr_reg,       addr_next;
  logic [CNT_W-1:0]   len_reg,        len_next;
  logic [CNT_W-1:0]   count_reg,      count_next;
  logic [7:0]         chk_reg,        chk_next;
  logic [DATA_W-1:0]  accum_reg,      accum_next;
  logic [TIMER_W-1:0] timer_reg,      timer_next;
  logic [ADDR_W-1:0]  rx_address_reg, rx_address_next;
  logic [DATA_W-1:0]  rx_data_reg,    rx_data_next;
  logic               rx_data_val_reg, rx_data_val_next;
  logic               rx_error_reg,   rx_error_next;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_reg        <= '0;
      len_reg         <= '0;
      count_reg       <= '0;
      chk_reg         <= '0;
      accum_reg       <= '0;
      timer_reg       <= '0;
      rx_address_reg  <= '0;
      rx_data_reg     <= '0;
      rx_data_val_reg <= 1'b0;
      rx_error_reg    <= 1'b0;
    end else begin
      addr_reg        <= addr_next;
      len_reg         <= len_next;
      count_reg       <= count_next;
      chk_reg         <= chk_next;
      accum_reg       <= accum_next;
      timer_reg       <= timer_next;
      rx_address_reg  <= rx_address_next;
      rx_data_reg     <= rx_data_next;
      rx_data_val_reg <= rx_data_val_next;
      rx_error_reg    <= rx_error_next;
    end
  end

  // Next-state and datapath logic
  rx_state_t        eff_state;
  logic             timed_out;
  logic [CNT_W-1:0] count_inc;

  always_comb begin
    state_next       = state_reg;
    addr_next        = addr_reg;
    len_next         = len_reg;
    count_next       = count_reg;
    chk_next         = chk_reg;
    accum_next       = accum_reg;
    timer_next       = timer_reg;
    rx_address_next  = rx_address_reg;
    rx_data_next     = rx_data_reg;
    rx_data_val_next = 1'b0;
    rx_error_next    = 1'b0;
    eff_state        = state_reg;
    timed_out        = 1'b0;
    count_inc        = count_reg + 1'b1;

    if (uartDisabled) begin
      // Silent abort: no error pulse, published outputs untouched.
      state_next = IDLE;
      timer_next = '0;
    end else begin
      // Expiry takes priority over a coincident byte; that byte is then
      // treated as if it arrived in IDLE so a fresh SOF is not lost.
      timed_out = (state_reg != IDLE) && (timer_reg == TIMER_LIMIT);
      if (timed_out) begin
        rx_error_next = 1'b1;
        eff_state     = IDLE;
        state_next    = IDLE;
      end

      // Timer saturates rather than wrapping so expiry cannot be skipped.
      if (eff_state == IDLE) begin
        timer_next = '0;
      end else if (timer_reg != TIMER_LIMIT) begin
        timer_next = timer_reg + 1'b1;
      end

      if (uart_rx_val) begin
        timer_next = '0;
        unique case (eff_state)
          IDLE: begin
            if (uart_rx_data == SOF_BYTE) begin
              state_next = ADDR;
              accum_next = '0;
              chk_next   = '0;
              count_next = '0;
            end
          end
          ADDR: begin
            if (uart_rx_data[7]) begin
              rx_error_next = 1'b1;
              state_next    = IDLE;
            end else begin
              addr_next  = uart_rx_data[ADDR_W-1:0];
              chk_next   = chk_reg ^ uart_rx_data;
              state_next = LEN;
            end
          end
          LEN: begin
            if ((uart_rx_data == 8'd0) || (uart_rx_data > LEN_LIMIT)) begin
              rx_error_next = 1'b1;
              state_next    = IDLE;
            end else begin
              len_next   = uart_rx_data[CNT_W-1:0];
              chk_next   = chk_reg ^ uart_rx_data;
              state_next = DATA;
            end
          end
          DATA: begin
            // Shift left so the first payload byte ends up most significant
            // within the right-aligned payload.
            accum_next = (accum_reg << 8) | DATA_W'(uart_rx_data);
            chk_next   = chk_reg ^ uart_rx_data;
            count_next = count_inc;
            if (count_inc == len_reg) begin
              state_next = CHK;
            end
          end
          CHK: begin
            if (uart_rx_data == chk_reg) begin
              rx_address_next  = addr_reg;
              rx_data_next     = accum_reg;
              rx_data_val_next = 1'b1;
            end else begin
              rx_error_next = 1'b1;
            end
            state_next = IDLE;
          end
          default: begin
            state_next = IDLE;
          end
        endcase
      end
    end
  end

  assign rx_address  = rx_address_reg;
  assign rx_data     = rx_data_reg;
  assign rx_data_val = rx_data_val_reg;
  assign rx_error    = rx_error_reg;

endmodule

// File: tb/tb_sysmon_frame_rx.sv
module tb_sysmon_frame_rx;
  import sysmon_pkg::*;

  localparam int MAX_LEN        = 10;
  localparam int TIMEOUT_CYCLES = 8389;

  logic                 clk;
  logic                 reset;
  logic [7:0]           uart_rx_data;
  logic                 uart_rx_val;
  logic                 uartDisabled;
  logic [ADDR_W-1:0]    rx_address;
  logic [8*MAX_LEN-1:0] rx_data;
  logic                 rx_data_val;
  logic                 rx_error;

  sysmon_frame_rx #(
    .MAX_LEN        (MAX_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .uart_rx_data (uart_rx_data),
    .uart_rx_val  (uart_rx_val),
    .uartDisabled (uartDisabled),
    .rx_address   (rx_address),
    .rx_data      (rx_data),
    .rx_data_val  (rx_data_val),
    .rx_error     (rx_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks_total  = 0;
  int checks_passed = 0;
  int val_cnt       = 0;
  int err_cnt       = 0;
  int overlap_cnt   = 0;

  always @(negedge clk) begin
    if (rx_data_val) val_cnt++;
    if (rx_error) err_cnt++;
    if (rx_data_val && rx_error) overlap_cnt++;
  end

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks_total++;
    if (got === exp) begin
      checks_passed++;
      $display("ok   %-14s got %h", tag, got);
    end else begin
      $display("FAIL %-14s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    uart_rx_data = b;
    uart_rx_val  = 1'b1;
    @(negedge clk);
    uart_rx_val  = 1'b0;
  endtask

  logic [7:0] fq[$];

  task automatic send_q();
    foreach (fq[i]) send_byte(fq[i]);
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  int v0, e0, n;

  initial begin
    reset        = 1'b1;
    uart_rx_data = 8'h00;
    uart_rx_val  = 1'b0;
    uartDisabled = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_addr", 80'(rx_address), 80'h0);
    check("rst_data", rx_data, 80'h0);
    check("rst_val", 80'(rx_data_val), 80'h0);
    check("rst_err", 80'(rx_error), 80'h0);
    reset = 1'b0;
    settle();

    // Good 2-byte frame, commit visible the cycle after CHK
    v0 = val_cnt; e0 = err_cnt;
    fq = '{8'hA5, 8'h05, 8'h02, 8'h00, 8'h0B, 8'h0C};
    send_q();
    check("f1_val_lat", 80'(rx_data_val), 80'h1);
    check("f1_addr", 80'(rx_address), 80'h05);
    check("f1_data", rx_data, 80'h000B);
    @(negedge clk);
    check("f1_val_1cyc", 80'(rx_data_val), 80'h0);
    settle();
    check("f1_nval", 80'(val_cnt - v0), 80'h1);
    check("f1_nerr", 80'(err_cnt - e0), 80'h0);

    // Bad checksum
    v0 = val_cnt; e0 = err_cnt;
    fq = '{8'hA5, 8'h04, 8'h02, 8'h01, 8'h23, 8'h25};
    send_q();
    check("chk_err_lat", 80'(rx_error), 80'h1);
    settle();
    check("chk_nerr", 80'(err_cnt - e0), 80'h1);
    check("chk_nval", 80'(val_cnt - v0), 80'h0);
    check("chk_addr_hold", 80'(rx_address), 80'h05);
    check("chk_data_hold", rx_data, 80'h000B);

    // Stalled frame times out
    v0 = val_cnt; e0 = err_cnt;
    fq = '{8'hA5, 8'h04, 8'h02, 8'h00};
    send_q();
    n = 0;
    while (!rx_error && n < 9000) begin
      @(negedge clk);
      n++;
    end
    check("to_seen", 80'(rx_error), 80'h1);
    check("to_latency", 80'(n), 80'(TIMEOUT_CYCLES + 1));
    settle();
    check("to_nerr", 80'(err_cnt - e0), 80'h1);
    check("to_nval", 80'(val_cnt - v0), 80'h0);
    fq = '{8'hA5, 8'h03, 8'h01, 8'h7E, 8'h7C};
    send_q();
    settle();
    check("to_next_addr", 80'(rx_address), 80'h03);
    check("to_next_data", rx_data, 80'h7E);

    // LEN out of range, then a frame whose payload is the SOF value
    v0 = val_cnt; e0 = err_cnt;
    fq = '{8'hA5, 8'h06, 8'h0B};
    send_q();
    check("len_err_lat", 80'(rx_error), 80'h1);
    fq = '{8'hA5, 8'h06, 8'h01, 8'hA5, 8'hA2};
    send_q();
    settle();
    check("len_nerr", 80'(err_cnt - e0), 80'h1);
    check("len_nval", 80'(val_cnt - v0), 80'h1);
    check("sofdat_addr", 80'(rx_address), 80'h06);
    check("sofdat_data", rx_data, 80'hA5);

    // Maximum length frame
    fq = '{8'hA5, 8'h07, 8'h0A, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
           8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h06};
    send_q();
    settle();
    check("max_addr", 80'(rx_address), 80'h07);
    check("max_data", rx_data, 80'h0102030405060708090A);

    // uartDisabled aborts a frame silently
    v0 = val_cnt; e0 = err_cnt;
    fq = '{8'hA5, 8'h05};
    send_q();
    uartDisabled = 1'b1;
    send_byte(8'h02);
    send_byte(8'hA5);
    uartDisabled = 1'b0;
    fq = '{8'h02, 8'h00, 8'h0B, 8'h0C};
    send_q();
    settle();
    check("dis_nval", 80'(val_cnt - v0), 80'h0);
    check("dis_nerr", 80'(err_cnt - e0), 80'h0);
    check("dis_addr_hold", 80'(rx_address), 80'h07);
    fq = '{8'hA5, 8'h01, 8'h01, 8'h55, 8'h55};
    send_q();
    settle();
    check("dis_next_addr", 80'(rx_address), 80'h01);
    check("dis_next_data", rx_data, 80'h55);

    // Reset mid-frame
    v0 = val_cnt; e0 = err_cnt;
    fq = '{8'hA5, 8'h05};
    send_q();
    reset = 1'b1;
    #1;
    check("mrst_addr", 80'(rx_address), 80'h0);
    check("mrst_data", rx_data, 80'h0);
    @(negedge clk);
    reset = 1'b0;
    fq = '{8'h02, 8'h00, 8'h0B, 8'h0C};
    send_q();
    settle();
    check("mrst_nval", 80'(val_cnt - v0), 80'h0);
    check("mrst_nerr", 80'(err_cnt - e0), 80'h0);
    fq = '{8'hA5, 8'h05, 8'h02, 8'h00, 8'h0B, 8'h0C};
    send_q();
    settle();
    check("mrst_next_addr", 80'(rx_address), 80'h05);
    check("mrst_next_data", rx_data, 80'h000B);

    check("no_overlap", 80'(overlap_cnt), 80'h0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
